// File: rtl/frogger_round_ctrl.sv
// Frogger round/lives sequencer: BCD round timer, lives and homes counters, phase flags for HUD and sprites.
// Define FROGGER_PAUSE_EN to add the pause_i input and paused_o output.
module frogger_round_ctrl #(
  parameter int ROUND_SECONDS  = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int START_LIVES    = 3,
  parameter int DEATH_FRAMES   = 60,
  parameter int HOMES          = 5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_clk_i,
  input  logic       game_start_i,
  input  logic       frog_hit_i,
  input  logic       frog_home_i,
`ifdef FROGGER_PAUSE_EN
  input  logic       pause_i,
  output logic       paused_o,
`endif
  output logic [3:0] tens_digit_o,
  output logic [3:0] ones_digit_o,
  output logic [2:0] lives_o,
  output logic [2:0] homes_filled_o,
  output logic       playing_o,
  output logic       frog_freeze_o,
  output logic       respawn_o,
  output logic       game_over_o,
  output logic       game_won_o
);

  localparam int PW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [3:0]    TENS_INIT  = 4'(ROUND_SECONDS / 10);
  localparam logic [3:0]    ONES_INIT  = 4'(ROUND_SECONDS % 10);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);
  localparam logic [2:0]    HOMES_WIN  = 3'(HOMES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(FRAMES_PER_SEC - 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_DYING, S_HOME, S_GAMEOVER, S_WIN
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sync_q;
  logic          tick_q;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] death_q, death_d;
  logic [2:0]    lives_q, lives_d, homes_q, homes_d;
  logic          pause_act;
  logic          timeout;

`ifdef FROGGER_PAUSE_EN
  logic paused_q;
  assign pause_act = (state_q == S_PLAY) && pause_i;
  assign paused_o  = paused_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) paused_q <= 1'b0;
    else         paused_q <= pause_act && !game_start_i;
  end
`else
  assign pause_act = 1'b0;
`endif

  // sync_q[0..1] is the two-flop synchroniser, sync_q[2] the edge-detect history.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk_i};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      tens_q  <= TENS_INIT;
      ones_q  <= ONES_INIT;
      presc_q <= '0;
      death_q <= '0;
      lives_q <= LIVES_INIT;
      homes_q <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      death_q <= death_d;
      lives_q <= lives_d;
      homes_q <= homes_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    death_d = death_q;
    lives_d = lives_q;
    homes_d = homes_q;
    timeout = 1'b0;

    if (game_start_i) begin
      state_d = S_LOAD;
      lives_d = LIVES_INIT;
      homes_d = '0;
    end else begin
      case (state_q)
        S_LOAD: state_d = S_PLAY;
        S_PLAY: begin
          if (!pause_act) begin
            if (tick_q) begin
              if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (ones_q != 4'd0) begin
                  ones_d  = ones_q - 4'd1;
                  timeout = (tens_q == 4'd0) && (ones_q == 4'd1);
                end else if (tens_q != 4'd0) begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
                end
              end else begin
                presc_d = presc_q + PW'(1);
              end
            end
            if (frog_home_i) begin
              state_d = S_HOME;
              homes_d = homes_q + 3'd1;
            end else if (frog_hit_i || timeout) begin
              state_d = S_DYING;
              death_d = '0;
            end
          end
        end
        S_DYING: begin
          if (tick_q) begin
            if (death_q == DEATH_LAST) begin
              death_d = '0;
              if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
              state_d = (lives_q <= 3'd1) ? S_GAMEOVER : S_LOAD;
            end else begin
              death_d = death_q + DW'(1);
            end
          end
        end
        S_HOME:  state_d = (homes_q == HOMES_WIN) ? S_WIN : S_LOAD;
        default: state_d = state_q;
      endcase
    end

    // Every entry into LOAD starts a fresh round timer.
    if (state_d == S_LOAD) begin
      tens_d  = TENS_INIT;
      ones_d  = ONES_INIT;
      presc_d = '0;
    end
  end

  assign tens_digit_o   = tens_q;
  assign ones_digit_o   = ones_q;
  assign lives_o        = lives_q;
  assign homes_filled_o = homes_q;
  assign playing_o      = (state_q == S_PLAY);
  assign frog_freeze_o  = (state_q == S_DYING);
  assign respawn_o      = (state_q == S_LOAD);
  assign game_over_o    = (state_q == S_GAMEOVER);
  assign game_won_o     = (state_q == S_WIN);

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Bench for frogger_round_ctrl: seconds-based behavioural model checked every cycle, plus literal scenario checks.
module tb_frogger_round_ctrl;
  localparam int RS = 12, FPS = 2, SL = 2, DF = 3, NH = 2;
  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_DYING = 3, P_HOME = 4, P_OVER = 5, P_WON = 6;

  logic clk = 1'b0;
  logic reset_i = 1'b1, frame_clk_i = 1'b0, game_start_i = 1'b0, frog_hit_i = 1'b0, frog_home_i = 1'b0;
  logic pause_i = 1'b0;
  logic paused_o;
  logic [3:0] tens_digit_o, ones_digit_o;
  logic [2:0] lives_o, homes_filled_o;
  logic playing_o, frog_freeze_o, respawn_o, game_over_o, game_won_o;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  frogger_round_ctrl #(
    .ROUND_SECONDS(RS), .FRAMES_PER_SEC(FPS), .START_LIVES(SL), .DEATH_FRAMES(DF), .HOMES(NH)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .frame_clk_i(frame_clk_i), .game_start_i(game_start_i),
    .frog_hit_i(frog_hit_i), .frog_home_i(frog_home_i),
`ifdef FROGGER_PAUSE_EN
    .pause_i(pause_i), .paused_o(paused_o),
`endif
    .tens_digit_o(tens_digit_o), .ones_digit_o(ones_digit_o), .lives_o(lives_o),
    .homes_filled_o(homes_filled_o), .playing_o(playing_o), .frog_freeze_o(frog_freeze_o),
    .respawn_o(respawn_o), .game_over_o(game_over_o), .game_won_o(game_won_o)
  );

`ifndef FROGGER_PAUSE_EN
  assign paused_o = 1'b0;
`endif

  // Inputs as seen by the active edge.
  logic s_rst = 1'b1, s_fc = 1'b0, s_gs = 1'b0, s_hit = 1'b0, s_home = 1'b0, s_pause = 1'b0;
  always @(posedge clk) begin
    s_rst <= reset_i; s_fc <= frame_clk_i; s_gs <= game_start_i;
    s_hit <= frog_hit_i; s_home <= frog_home_i; s_pause <= pause_i;
  end

  // Model: seconds left as an integer, frame_clk samples kept as a short history.
  int m_phase = P_IDLE, m_secs = RS, m_frames = 0, m_dticks = 0, m_lives = SL, m_homes = 0;
  bit m_paused = 0;
  bit fc_hist [1:4];

  task automatic new_round();
    m_phase = P_LOAD; m_secs = RS; m_frames = 0;
  endtask

  task automatic model_step();
    bit tick, pz, timeout;
    if (s_rst) begin
      m_phase = P_IDLE; m_secs = RS; m_frames = 0; m_dticks = 0; m_lives = SL; m_homes = 0;
      m_paused = 0;
      for (int i = 1; i <= 4; i++) fc_hist[i] = 0;
      return;
    end
    tick = fc_hist[3] && !fc_hist[4];
    for (int i = 4; i > 1; i--) fc_hist[i] = fc_hist[i-1];
    fc_hist[1] = s_fc;
`ifdef FROGGER_PAUSE_EN
    pz = (m_phase == P_PLAY) && s_pause;
`else
    pz = 0;
`endif
    m_paused = pz && !s_gs;
    timeout = 0;
    if (s_gs) begin
      m_lives = SL; m_homes = 0; new_round();
    end else begin
      case (m_phase)
        P_LOAD: m_phase = P_PLAY;
        P_PLAY: if (!pz) begin
          if (tick) begin
            m_frames++;
            if (m_frames == FPS) begin
              m_frames = 0;
              if (m_secs > 0) begin m_secs--; timeout = (m_secs == 0); end
            end
          end
          if (s_home) begin m_homes++; m_phase = P_HOME; end
          else if (s_hit || timeout) begin m_dticks = 0; m_phase = P_DYING; end
        end
        P_DYING: if (tick) begin
          m_dticks++;
          if (m_dticks == DF) begin
            if (m_lives > 0) m_lives--;
            if (m_lives == 0) m_phase = P_OVER; else new_round();
          end
        end
        P_HOME: if (m_homes == NH) m_phase = P_WON; else new_round();
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] act, exp;
    model_step();
    if (chk_en) begin
      act = {tens_digit_o, ones_digit_o, lives_o, homes_filled_o, playing_o, frog_freeze_o,
             respawn_o, game_over_o, game_won_o, paused_o};
      exp = {4'(m_secs / 10), 4'(m_secs % 10), 3'(m_lives), 3'(m_homes), m_phase == P_PLAY,
             m_phase == P_DYING, m_phase == P_LOAD, m_phase == P_OVER, m_phase == P_WON, m_paused};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise(int n);
    repeat (n) begin
      frame_clk_i = 1'b1; cyc(2);
      frame_clk_i = 1'b0; cyc(2);
    end
  endtask

  task automatic pulse_start();
    game_start_i = 1'b1; cyc(1); game_start_i = 1'b0;
  endtask

  initial begin
    int fc_run;
    cyc(2);
    reset_i = 1'b0;
    chk_en = 1;
    chk("rst_tens", tens_digit_o, 1);
    chk("rst_ones", ones_digit_o, 2);
    chk("rst_lives", lives_o, 2);
    chk("rst_homes", homes_filled_o, 0);
    chk("rst_flags", {playing_o, frog_freeze_o, respawn_o, game_over_o, game_won_o}, 0);

    // Countdown and borrow
    pulse_start();
    chk("load_respawn", respawn_o, 1);
    cyc(1);
    chk("play_flag", {playing_o, respawn_o}, 2'b10);
    rise(2);  chk("digits_11", {tens_digit_o, ones_digit_o}, 8'h11);
    rise(2);  chk("digits_10", {tens_digit_o, ones_digit_o}, 8'h10);
    rise(2);  chk("digits_09", {tens_digit_o, ones_digit_o}, 8'h09);

    // Timeout death, then respawn
    rise(18);
    chk("timeout_00", {tens_digit_o, ones_digit_o}, 8'h00);
    chk("timeout_dying", frog_freeze_o, 1);
    rise(3);
    chk("death_lives", lives_o, 1);
    chk("death_respawn", respawn_o, 1);
    chk("death_reload", {tens_digit_o, ones_digit_o}, 8'h12);

    // Last life lost
    cyc(1);
    frog_hit_i = 1'b1; cyc(1); frog_hit_i = 1'b0;
    chk("hit_freeze", frog_freeze_o, 1);
    rise(3);
    chk("over_lives", lives_o, 0);
    chk("over_flag", game_over_o, 1);
    rise(2);
    chk("over_hold", {game_over_o, lives_o, tens_digit_o, ones_digit_o}, {1'b1, 3'd0, 8'h12});

    // Homes and win, home beats hit
    pulse_start(); cyc(1);
    rise(1);
    frog_home_i = 1'b1; cyc(1); frog_home_i = 1'b0;
    chk("home1_cnt", homes_filled_o, 1);
    cyc(1);
    chk("home1_reload", {respawn_o, tens_digit_o, ones_digit_o}, {1'b1, 8'h12});
    cyc(1);
    frog_home_i = 1'b1; frog_hit_i = 1'b1; cyc(1); frog_home_i = 1'b0; frog_hit_i = 1'b0;
    chk("home_prio", {homes_filled_o, frog_freeze_o}, {3'd2, 1'b0});
    cyc(1);
    chk("won_flag", game_won_o, 1);

    // Restart from DYING, then reset mid-second
    pulse_start(); cyc(1);
    frog_hit_i = 1'b1; cyc(1); frog_hit_i = 1'b0;
    rise(1);
    pulse_start();
    chk("restart_load", {respawn_o, lives_o, homes_filled_o, tens_digit_o, ones_digit_o},
        {1'b1, 3'd2, 3'd0, 8'h12});
    cyc(1); rise(3);
    reset_i = 1'b1; cyc(1); reset_i = 1'b0;
    chk("mid_reset", {playing_o, respawn_o, lives_o, tens_digit_o, ones_digit_o},
        {2'b00, 3'd2, 8'h12});

`ifdef FROGGER_PAUSE_EN
    pulse_start(); cyc(1); rise(1);
    pause_i = 1'b1;
    rise(5);
    frog_hit_i = 1'b1; cyc(1); frog_hit_i = 1'b0;
    rise(5);
    chk("pause_hold", {paused_o, playing_o, lives_o, tens_digit_o, ones_digit_o},
        {2'b11, 3'd2, 8'h12});
    pause_i = 1'b0;
    rise(1);
    chk("pause_resume", {tens_digit_o, ones_digit_o}, 8'h11);
`endif

    // Randomized play
    fc_run = 1;
    for (int i = 0; i < 4000; i++) begin
      fc_run--;
      if (fc_run <= 0) begin frame_clk_i = ~frame_clk_i; fc_run = $urandom_range(1, 3); end
      game_start_i = ($urandom_range(0, 99) == 0);
      frog_hit_i   = ($urandom_range(0, 39) == 0);
      frog_home_i  = ($urandom_range(0, 59) == 0);
      reset_i      = ($urandom_range(0, 499) == 0);
`ifdef FROGGER_PAUSE_EN
      if ($urandom_range(0, 29) == 0) pause_i = ~pause_i;
`endif
      cyc(1);
    end
    game_start_i = 1'b0; frog_hit_i = 1'b0; frog_home_i = 1'b0; reset_i = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
